// File: rtl/motorola_16_slave_to_w32.sv
// 68000 bus responder: each decoded asynchronous 68000 cycle becomes one 32-bit
// Wishbone master cycle, answered on the 68000 side with _DTACK or _BERR.
module motorola_16_slave_to_w32 #(
    parameter logic [23:0] BASE_ADDR = 24'h000000,
    parameter logic [23:0] ADDR_MASK = 24'hFF0000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        wCLK,
    input  logic        wRST,
    input  logic        _AS,
    input  logic        _UDS,
    input  logic        _LDS,
    input  logic        R_W,
    input  logic [23:1] A,
    input  logic [15:0] D_i,
    output logic [15:0] D_o,
    output logic        D_oe,
    output logic        _DTACK,
    output logic        _BERR,
    output logic        sel,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [29:0] ADR_O,
    output logic [3:0]  SEL_O,
    output logic [31:0] DAT_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I,
    input  logic        ERR_I
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUS,
        ST_DONE,
        ST_FAIL,
        ST_ABORT
    } state_e;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W:0] TIMEOUT_V = TIMEOUT[CNT_W:0];
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);

    // ------------------------------------------------------------------
    // Strobe synchronizers
    // ------------------------------------------------------------------
    logic [1:0] as_sync_q;
    logic [1:0] uds_sync_q;
    logic [1:0] lds_sync_q;
    logic       as_s;
    logic       uds_s;
    logic       lds_s;

    // NOTE: synchronizers reset to 1 so an idle (high) strobe is never seen as a cycle start.
    always_ff @(posedge wCLK or posedge wRST) begin
        if (wRST) begin
            as_sync_q  <= 2'b11;
            uds_sync_q <= 2'b11;
            lds_sync_q <= 2'b11;
        end else begin
            as_sync_q  <= {as_sync_q[0], _AS};
            uds_sync_q <= {uds_sync_q[0], _UDS};
            lds_sync_q <= {lds_sync_q[0], _LDS};
        end
    end

    assign as_s  = as_sync_q[1];
    assign uds_s = uds_sync_q[1];
    assign lds_s = lds_sync_q[1];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               armed_q,   armed_d;
    logic               cyc_q,     cyc_d;
    logic               we_q,      we_d;
    logic [29:0]        adr_q,     adr_d;
    logic [3:0]         wsel_q,    wsel_d;
    logic [31:0]        dat_q,     dat_d;
    logic               rd_q,      rd_d;
    logic               a1_q,      a1_d;
    logic [15:0]        dout_q,    dout_d;
    logic               doe_q,     doe_d;
    logic               dtack_n_q, dtack_n_d;
    logic               berr_n_q,  berr_n_d;
    logic               sel_q,     sel_d;

    logic               hit;
    logic               start;
    logic [CNT_W:0]     cnt_inc;
    logic               timeout_hit;
    logic [15:0]        rd_word;
    logic               rel;

    assign hit         = ((({A, 1'b0} ^ BASE_ADDR) & ADDR_MASK) == 24'h000000);
    // A new cycle needs _AS to have been seen high since the previous start.
    assign start       = armed_q && !as_s && (!uds_s || !lds_s) && hit;
    assign cnt_inc     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign timeout_hit = TIMEOUT_EN && (cnt_inc == TIMEOUT_V);
    assign rd_word     = a1_q ? DAT_I[15:0] : DAT_I[31:16];

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        armed_d   = armed_q | as_s;
        cyc_d     = cyc_q;
        we_d      = we_q;
        adr_d     = adr_q;
        wsel_d    = wsel_q;
        dat_d     = dat_q;
        rd_d      = rd_q;
        a1_d      = a1_q;
        dout_d    = dout_q;
        doe_d     = doe_q;
        dtack_n_d = dtack_n_q;
        berr_n_d  = berr_n_q;
        sel_d     = sel_q;
        rel       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUS;
                    armed_d = 1'b0;
                    cnt_d   = '0;
                    cyc_d   = 1'b1;
                    we_d    = ~R_W;
                    rd_d    = R_W;
                    a1_d    = A[1];
                    adr_d   = {8'h00, A[23:2]};
                    wsel_d  = A[1] ? {2'b00, ~uds_s, ~lds_s} : {~uds_s, ~lds_s, 2'b00};
                    dat_d   = {D_i, D_i};
                    sel_d   = 1'b1;
                end
            end

            ST_BUS: begin
                cnt_d = cnt_inc[CNT_W-1:0];
                if (ERR_I || timeout_hit) begin
                    cyc_d    = 1'b0;
                    berr_n_d = 1'b0;
                    state_d  = ST_FAIL;
                end else if (ACK_I) begin
                    cyc_d     = 1'b0;
                    dtack_n_d = 1'b0;
                    doe_d     = rd_q;
                    if (rd_q) begin
                        dout_d = rd_word;
                    end
                    state_d   = ST_DONE;
                end else if (as_s) begin
                    state_d = ST_ABORT;
                end
            end

            ST_DONE, ST_FAIL: begin
                if (as_s) begin
                    rel = 1'b1;
                end
            end

            // The CPU has gone; finish the Wishbone cycle and drop the result.
            ST_ABORT: begin
                cnt_d = cnt_inc[CNT_W-1:0];
                if (ACK_I || ERR_I || timeout_hit) begin
                    rel = 1'b1;
                end
            end

            default: begin
                rel = 1'b1;
            end
        endcase

        if (rel) begin
            state_d   = ST_IDLE;
            cyc_d     = 1'b0;
            we_d      = 1'b0;
            adr_d     = '0;
            wsel_d    = '0;
            dat_d     = '0;
            dout_d    = '0;
            doe_d     = 1'b0;
            dtack_n_d = 1'b1;
            berr_n_d  = 1'b1;
            sel_d     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge wCLK or posedge wRST) begin
        if (wRST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            armed_q   <= 1'b1;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            wsel_q    <= '0;
            dat_q     <= '0;
            rd_q      <= 1'b0;
            a1_q      <= 1'b0;
            dout_q    <= '0;
            doe_q     <= 1'b0;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
            sel_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            wsel_q    <= wsel_d;
            dat_q     <= dat_d;
            rd_q      <= rd_d;
            a1_q      <= a1_d;
            dout_q    <= dout_d;
            doe_q     <= doe_d;
            dtack_n_q <= dtack_n_d;
            berr_n_q  <= berr_n_d;
            sel_q     <= sel_d;
        end
    end

    assign CYC_O  = cyc_q;
    assign STB_O  = cyc_q;
    assign WE_O   = we_q;
    assign ADR_O  = adr_q;
    assign SEL_O  = wsel_q;
    assign DAT_O  = dat_q;
    assign D_o    = dout_q;
    assign D_oe   = doe_q;
    assign _DTACK = dtack_n_q;
    assign _BERR  = berr_n_q;
    assign sel    = sel_q;

endmodule

// File: tb/tb_motorola_16_slave_to_w32.sv
// Scoreboard bench for motorola_16_slave_to_w32: randomized 68000 cycles against
// a byte-lane reference model, with a Wishbone slave model and a decoupled monitor.
`timescale 1ns/1ps
module tb_motorola_16_slave_to_w32;

    localparam logic [23:0] BASE = 24'h000000;
    localparam logic [23:0] MASK = 24'hFF0000;
    localparam int          TMO  = 8;

    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_BOTH = 2;
    localparam int M_NONE = 3;

    typedef struct {
        logic [29:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] dat;
    } wb_t;

    typedef struct {
        logic        berr;
        logic        is_read;
        logic [15:0] d_o;
        int          cyc_len;
    } resp_t;

    logic        wCLK;
    logic        wRST;
    logic        _AS;
    logic        _UDS;
    logic        _LDS;
    logic        R_W;
    logic [23:1] A;
    logic [15:0] D_i;
    logic [15:0] D_o;
    logic        D_oe;
    logic        _DTACK;
    logic        _BERR;
    logic        sel;
    logic        CYC_O;
    logic        STB_O;
    logic        WE_O;
    logic [29:0] ADR_O;
    logic [3:0]  SEL_O;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I;
    logic        ACK_I;
    logic        ERR_I;

    wb_t   wb_q[$];
    resp_t resp_q[$];
    int    n_checks  = 0;
    int    n_errors  = 0;
    int    slv_mode  = M_ACK;
    int    slv_delay = 0;

    motorola_16_slave_to_w32 #(
        .BASE_ADDR(BASE),
        .ADDR_MASK(MASK),
        .TIMEOUT  (TMO)
    ) dut (
        .wCLK  (wCLK),
        .wRST  (wRST),
        ._AS   (_AS),
        ._UDS  (_UDS),
        ._LDS  (_LDS),
        .R_W   (R_W),
        .A     (A),
        .D_i   (D_i),
        .D_o   (D_o),
        .D_oe  (D_oe),
        ._DTACK(_DTACK),
        ._BERR (_BERR),
        .sel   (sel),
        .CYC_O (CYC_O),
        .STB_O (STB_O),
        .WE_O  (WE_O),
        .ADR_O (ADR_O),
        .SEL_O (SEL_O),
        .DAT_O (DAT_O),
        .DAT_I (DAT_I),
        .ACK_I (ACK_I),
        .ERR_I (ERR_I)
    );

    initial begin
        wCLK = 1'b0;
        forever #5 wCLK = ~wCLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=no finish by time limit, required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: big-endian byte lanes from plain address arithmetic.
    function automatic logic decoded(input logic [23:0] ba);
        return (ba & MASK) == (BASE & MASK);
    endfunction

    function automatic wb_t model_wb(input logic [23:0] ba, input logic rd, input logic use_u,
                                     input logic use_l, input logic [15:0] wdata);
        wb_t w;
        int  off;
        off   = int'(ba % 4);
        w.adr = 30'(ba / 4);
        w.sel = 4'b0000;
        if (use_u) w.sel[3 - off] = 1'b1;
        if (use_l) w.sel[2 - off] = 1'b1;
        w.we  = ~rd;
        w.dat = {wdata, wdata};
        return w;
    endfunction

    function automatic resp_t model_resp(input logic [23:0] ba, input logic rd, input logic [31:0] sdata,
                                         input int mode, input int dly);
        resp_t r;
        int    off;
        off       = int'(ba % 4);
        r.berr    = (mode != M_ACK);
        r.is_read = rd && (mode == M_ACK);
        r.d_o     = {sdata[8*(3-off) +: 8], sdata[8*(2-off) +: 8]};
        r.cyc_len = (mode == M_NONE) ? TMO : dly + 1;
        return r;
    endfunction

    // Wishbone slave: answers after slv_delay cycles of CYC/STB, per slv_mode.
    initial begin : slave
        int waited;
        waited = 0;
        ACK_I  = 1'b0;
        ERR_I  = 1'b0;
        forever begin
            @(negedge wCLK);
            ACK_I = 1'b0;
            ERR_I = 1'b0;
            if (CYC_O === 1'b1 && STB_O === 1'b1) begin
                if (slv_mode != M_NONE && waited >= slv_delay) begin
                    ACK_I  = (slv_mode == M_ACK) || (slv_mode == M_BOTH);
                    ERR_I  = (slv_mode == M_ERR) || (slv_mode == M_BOTH);
                    waited = 0;
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT starts a Wishbone cycle or answers the CPU.
    initial begin : monitor
        logic  cyc_prev;
        logic  dt_prev;
        logic  be_prev;
        int    cyc_len;
        wb_t   w;
        resp_t r;
        cyc_prev = 1'b0;
        dt_prev  = 1'b1;
        be_prev  = 1'b1;
        cyc_len  = 0;
        forever begin
            @(posedge wCLK);
            #2;
            if (CYC_O === 1'b1 && cyc_prev !== 1'b1) begin
                cyc_len = 0;
                if (wb_q.size() == 0) begin
                    check("wb_unexpected_cycle", 1, 0);
                end else begin
                    w = wb_q.pop_front();
                    check("wb_adr", ADR_O, w.adr);
                    check("wb_sel", SEL_O, w.sel);
                    check("wb_we", WE_O, w.we);
                    check("wb_dat", DAT_O, w.dat);
                    check("wb_stb_sel", {STB_O, sel}, 2'b11);
                end
            end
            if (CYC_O === 1'b1) cyc_len++;
            if (_DTACK === 1'b0 && dt_prev === 1'b1) begin
                if (resp_q.size() == 0) begin
                    check("dtack_unexpected", 1, 0);
                end else begin
                    r = resp_q.pop_front();
                    check("dtack_kind", r.berr, 0);
                    check("dtack_berr_high", _BERR, 1);
                    check("dtack_on_ack_edge", ACK_I, 1);
                    check("dtack_cyc_len", cyc_len, r.cyc_len);
                    check("dtack_cyc_dropped", {CYC_O, STB_O}, 2'b00);
                    check("dtack_d_oe", D_oe, r.is_read);
                    if (r.is_read) check("dtack_d_o", D_o, r.d_o);
                    check("dtack_sel", sel, 1);
                end
            end
            if (_BERR === 1'b0 && be_prev === 1'b1) begin
                if (resp_q.size() == 0) begin
                    check("berr_unexpected", 1, 0);
                end else begin
                    r = resp_q.pop_front();
                    check("berr_kind", r.berr, 1);
                    check("berr_dtack_high", _DTACK, 1);
                    check("berr_cyc_len", cyc_len, r.cyc_len);
                    check("berr_cyc_dropped", {CYC_O, STB_O}, 2'b00);
                    check("berr_d_oe", D_oe, 0);
                    check("berr_sel", sel, 1);
                end
            end
            cyc_prev = CYC_O;
            dt_prev  = _DTACK;
            be_prev  = _BERR;
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_dtack_berr"}, {_DTACK, _BERR}, 2'b11);
        check({tag, "_d_oe"}, D_oe, 0);
        check({tag, "_d_o"}, D_o, 0);
        check({tag, "_sel"}, sel, 0);
        check({tag, "_cyc_stb_we"}, {CYC_O, STB_O, WE_O}, 3'b000);
        check({tag, "_adr"}, ADR_O, 0);
        check({tag, "_wsel"}, SEL_O, 0);
        check({tag, "_dat"}, DAT_O, 0);
    endtask

    task automatic m68k_cycle(input logic [23:0] ba, input logic rd, input logic use_u, input logic use_l,
                              input logic [15:0] wdata, input logic [31:0] sdata,
                              input int mode, input int dly, input logic abort_it);
        logic dec;
        logic bad;
        int   n;
        @(negedge wCLK);
        A         = ba[23:1];
        R_W       = rd;
        D_i       = wdata;
        DAT_I     = sdata;
        slv_mode  = mode;
        slv_delay = dly;
        dec       = decoded(ba);
        if (dec) begin
            wb_q.push_back(model_wb(ba, rd, use_u, use_l, wdata));
            if (!abort_it) resp_q.push_back(model_resp(ba, rd, sdata, mode, dly));
        end
        @(negedge wCLK);
        _AS = 1'b0;
        if (!rd) @(negedge wCLK);
        _UDS = ~use_u;
        _LDS = ~use_l;

        if (!dec) begin
            bad = 1'b0;
            repeat (8) begin
                @(negedge wCLK);
                bad = bad | sel | CYC_O | ~_DTACK | ~_BERR;
            end
            check("undecoded_quiet", bad, 0);
            _AS = 1'b1; _UDS = 1'b1; _LDS = 1'b1;
            repeat (3) @(negedge wCLK);
        end else if (abort_it) begin
            n = 0;
            while (CYC_O !== 1'b1 && n < 20) begin
                @(negedge wCLK);
                n++;
            end
            check("abort_cyc_start", CYC_O, 1);
            _AS = 1'b1; _UDS = 1'b1; _LDS = 1'b1;
            repeat (3) @(negedge wCLK);
            check("abort_cyc_held", CYC_O, 1);
            n = 0;
            while (CYC_O !== 1'b0 && n < 20) begin
                @(negedge wCLK);
                n++;
            end
            check("abort_cyc_end", CYC_O, 0);
            repeat (3) @(negedge wCLK);
            check("abort_no_response", {_DTACK, _BERR, sel}, 3'b110);
        end else begin
            n = 0;
            while (_DTACK === 1'b1 && _BERR === 1'b1 && n < 40) begin
                @(negedge wCLK);
                n++;
            end
            check("response_arrived", {_DTACK, _BERR} != 2'b11, 1);
            repeat ($urandom_range(0, 2)) @(negedge wCLK);
            check("response_held", {_DTACK, _BERR} != 2'b11, 1);
            _AS = 1'b1; _UDS = 1'b1; _LDS = 1'b1;
            n = 0;
            while (!(_DTACK === 1'b1 && _BERR === 1'b1 && sel === 1'b0) && n < 10) begin
                @(negedge wCLK);
                n++;
            end
            check("response_released", {_DTACK, _BERR, sel}, 3'b110);
            check("release_d_oe_d_o", {D_oe, D_o}, 0);
            check("release_wb", {CYC_O, WE_O, ADR_O, SEL_O}, 0);
            @(negedge wCLK);
        end
    endtask

    initial begin : stim
        logic [23:0] ba;
        logic        rd;
        logic        use_u;
        logic        use_l;
        logic        ab;
        int          st;
        int          pick;
        int          mode;
        int          dly;
        int          n;

        wRST = 1'b0;
        _AS  = 1'b1;
        _UDS = 1'b1;
        _LDS = 1'b1;
        R_W  = 1'b1;
        A    = '0;
        D_i  = '0;
        DAT_I = '0;
        #1 wRST = 1'b1;
        repeat (3) @(negedge wCLK);
        check_reset_values("reset");
        wRST = 1'b0;
        repeat (2) @(negedge wCLK);

        // Directed cycles.
        m68k_cycle(24'h000004, 1'b1, 1'b1, 1'b1, 16'hC0DE, 32'h1234_5678, M_ACK, 2, 1'b0);
        m68k_cycle(24'h000006, 1'b0, 1'b0, 1'b1, 16'h5AAB, 32'hDEAD_BEEF, M_ACK, 1, 1'b0);
        m68k_cycle(24'h010000, 1'b1, 1'b1, 1'b1, 16'h0F0F, 32'h0BAD_0BAD, M_ACK, 0, 1'b0);
        m68k_cycle(24'h000010, 1'b1, 1'b1, 1'b1, 16'h1111, 32'h5555_AAAA, M_NONE, 0, 1'b0);
        m68k_cycle(24'h000012, 1'b1, 1'b1, 1'b1, 16'h2222, 32'hCAFE_F00D, M_BOTH, 1, 1'b0);
        m68k_cycle(24'h000020, 1'b1, 1'b1, 1'b1, 16'h3333, 32'h7777_8888, M_ACK, 5, 1'b1);
        m68k_cycle(24'h00FFFE, 1'b1, 1'b1, 1'b1, 16'h4444, 32'hA1B2_C3D4, M_ACK, 0, 1'b0);
        m68k_cycle(24'h00FFFC, 1'b0, 1'b1, 1'b0, 16'h9A00, 32'h0000_0000, M_ERR, 3, 1'b0);

        // Randomized cycles.
        for (int i = 0; i < 48; i++) begin
            ba = 24'($urandom) & 24'h00FFFE;
            if ($urandom_range(0, 9) == 0) ba[23:16] = 8'($urandom_range(1, 255));
            rd    = 1'($urandom);
            st    = $urandom_range(0, 2);
            use_u = (st != 2);
            use_l = (st != 1);
            pick  = $urandom_range(0, 99);
            mode  = (pick < 60) ? M_ACK : (pick < 75) ? M_ERR : (pick < 85) ? M_BOTH : M_NONE;
            dly   = $urandom_range(0, 5);
            ab    = ($urandom_range(0, 9) == 0);
            if (ab && mode != M_NONE) dly = 5;
            m68k_cycle(ba, rd, use_u, use_l, 16'($urandom), $urandom, mode, dly, ab);
        end

        // Asynchronous reset in the middle of a Wishbone cycle.
        @(negedge wCLK);
        ba        = 24'h000040;
        A         = ba[23:1];
        R_W       = 1'b1;
        D_i       = 16'h6666;
        slv_mode  = M_NONE;
        wb_q.push_back(model_wb(ba, 1'b1, 1'b1, 1'b1, 16'h6666));
        @(negedge wCLK);
        _AS = 1'b0; _UDS = 1'b0; _LDS = 1'b0;
        n = 0;
        while (CYC_O !== 1'b1 && n < 20) begin
            @(negedge wCLK);
            n++;
        end
        check("midreset_cyc_start", CYC_O, 1);
        #3 wRST = 1'b1;
        #1 check_reset_values("midreset");
        @(negedge wCLK);
        _AS = 1'b1; _UDS = 1'b1; _LDS = 1'b1;
        repeat (2) @(negedge wCLK);
        wRST = 1'b0;
        repeat (2) @(negedge wCLK);

        m68k_cycle(24'h000044, 1'b1, 1'b1, 1'b1, 16'h7777, 32'h89AB_CDEF, M_ACK, 0, 1'b0);

        repeat (5) @(negedge wCLK);
        check("wb_queue_drained", wb_q.size(), 0);
        check("resp_queue_drained", resp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
